// File: rtl/sbb32_serial.sv
// rtl/sbb32_serial.sv - multi-cycle DIGIT-sliced subtract-with-borrow unit
//
// Computes D = A - B - BIN one DIGIT-wide slice per clock, LSB slice first,
// with a start/busy/done handshake. WIDTH must be a multiple of DIGIT.
//
// Ports:
//   clk       in   1        clock, rising edge
//   rst       in   1        asynchronous, active-high reset
//   start     in   1        request, sampled only while not busy
//   A         in   WIDTH    minuend, captured on the accepted start edge
//   B         in   WIDTH    subtrahend, captured on the accepted start edge
//   BIN       in   1        borrow-in, captured on the accepted start edge
//   busy      out  1        operation in progress (start ignored)
//   done      out  1        one-cycle pulse, D/overflow valid
//   D         out  WIDTH+1  {borrow-out, difference}
//   overflow  out  1        signed two's-complement overflow

module sbb32_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   D,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;      // operands shift right one slice per cycle
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;      // difference slices enter at the top
    logic             brw;      // borrow chained between slices
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] diff_next;

    // The extra top bit of the (DIGIT+1)-bit difference goes negative
    // exactly when the slice underflows, i.e. it is the slice borrow-out.
    always_comb begin
        slice     = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, brw};
        diff_next = (acc >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            D        <= '0;
            overflow <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                // DONE accepts a new start just like IDLE, giving back-to-back ops.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        brw   <= BIN;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r <= a_r >> DIGIT;
                    b_r <= b_r >> DIGIT;
                    brw <= slice[DIGIT];
                    acc <= diff_next;
                    if (cnt == LAST) begin
                        // Top slice still holds the operand sign bits here.
                        D        <= {slice[DIGIT], diff_next};
                        overflow <= (a_r[DIGIT-1] != b_r[DIGIT-1]) &&
                                    (slice[DIGIT-1] != a_r[DIGIT-1]);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbb32_serial.sv
// tb/tb_sbb32_serial.sv - self-checking bench for sbb32_serial

module tb_sbb32_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BIN = 1'b0;
    logic        busy;
    logic        done;
    logic [32:0] D;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    sbb32_serial #(.WIDTH(32), .DIGIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .BIN      (BIN),
        .busy     (busy),
        .done     (done),
        .D        (D),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to the output fields.
    function automatic logic [32:0] ref_d(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint unsigned ua, ub;
        logic [31:0]     lo;
        ua = longint'(a);
        ub = longint'(b) + longint'(bin);
        lo = 32'(ua - ub);
        return {(ua < ub), lo};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint s;
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Called at a negedge: raises start, then waits for done. With noise set,
    // extra starts and operand churn are driven while busy and must be ignored.
    // Returns at the negedge where done is observed, with start low.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic bin, input bit noise);
        logic [32:0] ed;
        logic        eo;
        int          lat;
        int          nbusy;
        ed    = ref_d(a, b, bin);
        eo    = ref_ovf(a, b, bin);
        A     = a;
        B     = b;
        BIN   = bin;
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
            if (lat > 1 && noise) begin
                D_hold_check(ed);
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            A     = $urandom;
            B     = $urandom;
            BIN   = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'd5);
        chk("busy_cycles", 64'(nbusy), 64'd4);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("D", 64'(D), 64'(ed));
        chk("overflow", 64'(overflow), 64'(eo));
    endtask

    // D must not show the pending result before done.
    task automatic D_hold_check(input logic [32:0] pending);
        if (pending != last_d) chk("D_hold_run", 64'(D), 64'(last_d));
    endtask

    logic [32:0] last_d = '0;

    initial begin
        int gap;
        logic [31:0] ra, rb;
        logic        rbin;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_D", 64'(D), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        op(32'd5, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        op(32'd0, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        op(32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        op(32'h8000_0000, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        op(32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("all_ones_borrow", 64'(D[32]), 64'd1);
        last_d = D;
        @(negedge clk);
        chk("hold_idle_D", 64'(D), 64'(last_d));

        // Start while busy is dropped, then a start in the DONE cycle is taken
        op(32'd9, 32'd4, 1'b0, 1'b1);
        chk("single_D", 64'(D[31:0]), 64'd5);
        last_d = D;
        op(32'd100, 32'd58, 1'b1, 1'b0);
        last_d = D;
        @(negedge clk);
        chk("no_queued_done", 64'(done), 64'd0);
        chk("no_queued_busy", 64'(busy), 64'd0);

        // Reset mid-operation aborts with no done
        A = 32'd77; B = 32'd3; BIN = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_D", 64'(D), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        gap = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) gap++;
        end
        chk("abort_no_done", 64'(gap), 64'd0);
        op(32'd10, 32'd10, 1'b0, 1'b0);
        last_d = D;

        // Random vectors with random gaps, including back-to-back starts
        for (int i = 0; i < 10000; i++) begin
            gap = $urandom_range(0, 1);
            repeat (gap) @(negedge clk);
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = 32'hFFFF_FFFF; end
                1: begin ra = $urandom_range(0, 3); rb = $urandom_range(0, 3); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rbin = 1'($urandom_range(0, 1));
            op(ra, rb, rbin, 1'($urandom_range(0, 1)));
            last_d = D;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
